// File: rtl/apb_fifo_slave.sv
// APB3 slave in front of a byte FIFO: DATA/STATUS/CTRL/THRESH registers, wait states,
// PSLVERR on overflow/underflow, sticky error flags, flush and a threshold interrupt.
module apb_fifo_slave #(
  parameter int DATA_W   = 8,
  parameter int ADD_W    = 8,
  parameter int DEPTH    = 8,
  parameter int WAIT_CYC = 0,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADD_W-1:0]  paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]      WAIT_C  = 4'(WAIT_CYC);
  localparam logic [1:0]      A_DATA   = 2'd0;
  localparam logic [1:0]      A_STATUS = 2'd1;
  localparam logic [1:0]      A_CTRL   = 2'd2;
  localparam logic [1:0]      A_THRESH = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             r_state, w_phase, w_stateNxt;
  logic [3:0]         r_wcnt, w_wcntNxt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rdPtr, r_wrPtr, w_rdPtrNxt, w_wrPtrNxt;
  logic [CNT_W-1:0]   r_count, w_countNxt;
  logic [CNT_W-1:0]   r_thresh, w_threshNxt;
  logic               r_overflow, r_underflow, r_irqEn, r_irq;
  logic               w_ovNxt, w_unNxt, w_irqEnNxt;
  logic               w_full, w_empty, w_commit, w_isData;
  logic               w_overErr, w_underErr, w_push, w_pop;
  logic               w_ctrlWr, w_flush, w_threshWr;
  logic [DATA_W-1:0]  w_regRd;
  logic               w_unused;

  assign w_unused = &{1'b0, paddr[ADD_W-1:2]};

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign pready  = (r_state == ACCESS) && (r_wcnt == WAIT_C);

  // A setup phase presented while idle is the SETUP cycle itself, so the
  // master's access phase lines up with our ACCESS state.
  always_comb begin
    w_phase    = r_state;
    w_stateNxt = r_state;
    w_wcntNxt  = r_wcnt;
    if (r_state == IDLE && psel && !penable) w_phase = SETUP;
    case (w_phase)
      IDLE:   w_stateNxt = IDLE;
      SETUP: begin
        w_stateNxt = ACCESS;
        w_wcntNxt  = '0;
      end
      ACCESS: begin
        if (pready) w_stateNxt = (psel && !penable) ? SETUP : IDLE;
        else if (r_wcnt != WAIT_C) w_wcntNxt = r_wcnt + 4'd1;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_wcnt  <= w_wcntNxt;
    end
  end

  assign w_commit   = pready && psel && penable;
  assign w_isData   = (paddr[1:0] == A_DATA);
  assign w_overErr  = w_isData && pwrite && w_full;
  assign w_underErr = w_isData && !pwrite && w_empty;
  assign pslverr    = pready && (w_overErr || w_underErr);
  assign w_push     = w_commit && w_isData && pwrite && !w_full;
  assign w_pop      = w_commit && w_isData && !pwrite && !w_empty;
  assign w_ctrlWr   = w_commit && pwrite && (paddr[1:0] == A_CTRL);
  assign w_flush    = w_ctrlWr && pwdata[0];
  assign w_threshWr = w_commit && pwrite && (paddr[1:0] == A_THRESH);

  // Post-commit values; the interrupt is computed from these so it tracks the commit.
  always_comb begin
    w_rdPtrNxt  = r_rdPtr;
    w_wrPtrNxt  = r_wrPtr;
    w_countNxt  = r_count;
    w_ovNxt     = r_overflow;
    w_unNxt     = r_underflow;
    w_irqEnNxt  = r_irqEn;
    w_threshNxt = r_thresh;
    if (w_push) begin
      w_wrPtrNxt = r_wrPtr + 1'b1;
      w_countNxt = r_count + 1'b1;
    end
    if (w_pop) begin
      w_rdPtrNxt = r_rdPtr + 1'b1;
      w_countNxt = r_count - 1'b1;
    end
    if (w_commit && w_overErr)  w_ovNxt = 1'b1;
    if (w_commit && w_underErr) w_unNxt = 1'b1;
    if (w_ctrlWr) w_irqEnNxt = pwdata[1];
    if (w_flush) begin
      w_rdPtrNxt = '0;
      w_wrPtrNxt = '0;
      w_countNxt = '0;
      w_ovNxt    = 1'b0;
      w_unNxt    = 1'b0;
    end
    if (w_threshWr) w_threshNxt = pwdata[CNT_W-1:0];
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_irqEn     <= 1'b0;
      r_thresh    <= DEPTH_C;
      r_irq       <= 1'b0;
    end else begin
      r_rdPtr     <= w_rdPtrNxt;
      r_wrPtr     <= w_wrPtrNxt;
      r_count     <= w_countNxt;
      r_overflow  <= w_ovNxt;
      r_underflow <= w_unNxt;
      r_irqEn     <= w_irqEnNxt;
      r_thresh    <= w_threshNxt;
      r_irq       <= w_irqEnNxt && ((w_countNxt >= w_threshNxt) || w_ovNxt || w_unNxt);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wrPtr] <= pwdata;
  end

  always_comb begin
    w_regRd = '0;
    case (paddr[1:0])
      A_DATA:   w_regRd = w_empty ? '0 : r_mem[r_rdPtr];
      A_STATUS: w_regRd = DATA_W'({r_count, r_underflow, r_overflow, w_full, w_empty});
      A_CTRL:   w_regRd = DATA_W'({r_irqEn, 1'b0});
      A_THRESH: w_regRd = DATA_W'(r_thresh);
      default:  w_regRd = '0;
    endcase
  end

  assign prdata = (pready && !pwrite) ? w_regRd : '0;
  assign irq    = r_irq;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Bench for apb_fifo_slave: a zero-wait and a 3-wait instance, directed vectors,
// corner sequences and random traffic against a queue-based register model.
module tb_apb_fifo_slave;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel0, psel3, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata0, prdata3;
  logic       pready0, pready3, pslverr0, pslverr3, irq0, irq3;
  logic       selDut;
  logic [7:0] curPrdata;
  logic       curPready, curPslverr, curIrq;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] mq[$];
  logic       mOv, mUn, mIrqEn;
  logic [3:0] mThresh;

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] expRd;
    bit         expErr;
  } vec_t;
  vec_t vecs[$];

  always #5 pclk = ~pclk;

  apb_fifo_slave #(.DATA_W(8), .ADD_W(8), .DEPTH(8), .WAIT_CYC(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .irq(irq0));

  apb_fifo_slave #(.DATA_W(8), .ADD_W(8), .DEPTH(8), .WAIT_CYC(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .irq(irq3));

  always_comb begin
    curPrdata  = selDut ? prdata3  : prdata0;
    curPready  = selDut ? pready3  : pready0;
    curPslverr = selDut ? pslverr3 : pslverr0;
    curIrq     = selDut ? irq3     : irq0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic modelReset();
    mq.delete();
    mOv = 1'b0; mUn = 1'b0; mIrqEn = 1'b0; mThresh = 4'd8;
  endtask

  task automatic doReset();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    preset = 1'b0;
    tick();
    tick();
    preset = 1'b1;
    tick();
    modelReset();
  endtask

  // One APB transfer; entered and left at 1ns after a rising edge, so calls chain back-to-back.
  task automatic applyStimulus(input bit dut, input bit wr, input logic [1:0] addr,
                               input logic [7:0] wd, output logic [7:0] rd, output logic err,
                               output int cyc, output int waits);
    bit done;
    selDut = dut;
    if (dut) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = {6'b0, addr}; pwdata = wd;
    cyc = 1; waits = 0; done = 0; rd = '0; err = 1'b0;
    tick();
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc++;
      @(negedge pclk);
      if (curPready === 1'b1) begin
        rd = curPrdata; err = curPslverr; done = 1;
      end else begin
        waits++;
      end
      tick();
    end
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    if (!done) checkOutput("bus timeout", 32'd0, 32'd1);
  endtask

  task automatic modelPredict(input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                              output logic [7:0] erd, output logic eerr);
    int cnt;
    logic [3:0] c4;
    erd = '0; eerr = 1'b0;
    cnt = mq.size();
    c4 = 4'(cnt);
    case (addr)
      2'd0: begin
        if (wr) begin
          if (cnt == 8) begin eerr = 1'b1; mOv = 1'b1; end
          else mq.push_back(wd);
        end else begin
          if (cnt == 0) begin eerr = 1'b1; mUn = 1'b1; end
          else erd = mq.pop_front();
        end
      end
      2'd1: if (!wr) erd = {c4, mUn, mOv, cnt == 8, cnt == 0};
      2'd2: begin
        if (wr) begin
          mIrqEn = wd[1];
          if (wd[0]) begin mq.delete(); mOv = 1'b0; mUn = 1'b0; end
        end else erd = {6'b0, mIrqEn, 1'b0};
      end
      default: begin
        if (wr) mThresh = wd[3:0];
        else erd = {4'b0, mThresh};
      end
    endcase
  endtask

  task automatic modelXfer(input bit dut, input bit wr, input logic [1:0] addr,
                           input logic [7:0] wd, input string tag);
    logic [7:0] erd, rd;
    logic       eerr, err, eirq;
    int         cyc, waits;
    modelPredict(wr, addr, wd, erd, eerr);
    eirq = mIrqEn && ((mq.size() >= int'(mThresh)) || mOv || mUn);
    applyStimulus(dut, wr, addr, wd, rd, err, cyc, waits);
    checkOutput($sformatf("%s prdata a%0d w%0d", tag, addr, wr), rd, erd);
    checkOutput($sformatf("%s pslverr a%0d w%0d", tag, addr, wr), err, eerr);
    checkOutput($sformatf("%s irq", tag), curIrq, eirq);
    checkOutput($sformatf("%s cycles", tag), cyc, dut ? 5 : 2);
  endtask

  function automatic vec_t mkVec(bit wr, logic [1:0] addr, logic [7:0] wd,
                                 logic [7:0] expRd, bit expErr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.expRd = expRd; v.expErr = expErr;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic       err;
    int         cyc, waits;

    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h01, 0));
    vecs.push_back(mkVec(0, 2'd3, 8'h00, 8'h08, 0));
    vecs.push_back(mkVec(0, 2'd2, 8'h00, 8'h00, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mkVec(1, 2'd0, 8'(8'hA0 + i), 8'h00, 0));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h82, 0));
    vecs.push_back(mkVec(1, 2'd0, 8'hFF, 8'h00, 1));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h86, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mkVec(0, 2'd0, 8'h00, 8'(8'hA0 + i), 0));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h05, 0));
    vecs.push_back(mkVec(0, 2'd0, 8'h00, 8'h00, 1));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h0D, 0));
    vecs.push_back(mkVec(1, 2'd2, 8'h01, 8'h00, 0));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h01, 0));
    vecs.push_back(mkVec(0, 2'd2, 8'h00, 8'h00, 0));
    vecs.push_back(mkVec(1, 2'd1, 8'h55, 8'h00, 0));
    vecs.push_back(mkVec(0, 2'd1, 8'h00, 8'h01, 0));
    vecs.push_back(mkVec(1, 2'd3, 8'hFB, 8'h00, 0));
    vecs.push_back(mkVec(0, 2'd3, 8'h00, 8'h0B, 0));
    vecs.push_back(mkVec(1, 2'd3, 8'h03, 8'h00, 0));
    vecs.push_back(mkVec(1, 2'd2, 8'h02, 8'h00, 0));
    vecs.push_back(mkVec(0, 2'd2, 8'h00, 8'h02, 0));

    selDut = 1'b0;
    doReset();
    checkOutput("reset irq0", irq0, 1'b0);
    checkOutput("reset pready0", pready0, 1'b0);
    checkOutput("reset prdata0", prdata0, 8'h00);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, err, cyc, waits);
      checkOutput($sformatf("vec%0d prdata", i), rd, vecs[i].expRd);
      checkOutput($sformatf("vec%0d pslverr", i), err, vecs[i].expErr);
      checkOutput($sformatf("vec%0d cycles", i), cyc, 2);
      checkOutput($sformatf("vec%0d irq", i), irq0, 1'b0);
    end

    // Threshold interrupt: THRESH=3, IRQ_EN=1 already programmed by the vectors.
    applyStimulus(0, 1, 2'd0, 8'h11, rd, err, cyc, waits);
    applyStimulus(0, 1, 2'd0, 8'h22, rd, err, cyc, waits);
    checkOutput("irq below thresh", irq0, 1'b0);
    applyStimulus(0, 1, 2'd0, 8'h33, rd, err, cyc, waits);
    checkOutput("irq at thresh", irq0, 1'b1);
    applyStimulus(0, 0, 2'd0, 8'h00, rd, err, cyc, waits);
    checkOutput("irq read data", rd, 8'h11);
    checkOutput("irq after read", irq0, 1'b0);

    // Wait states and back-to-back transfers on the 3-wait instance.
    applyStimulus(1, 0, 2'd1, 8'h00, rd, err, cyc, waits);
    checkOutput("w3 status", rd, 8'h01);
    checkOutput("w3 cycles", cyc, 5);
    checkOutput("w3 waits", waits, 3);
    applyStimulus(1, 1, 2'd0, 8'h5A, rd, err, cyc, waits);
    applyStimulus(1, 1, 2'd0, 8'h5B, rd, err, cyc, waits);
    checkOutput("w3 b2b cycles", cyc, 5);
    applyStimulus(1, 0, 2'd1, 8'h00, rd, err, cyc, waits);
    checkOutput("w3 b2b status", rd, 8'h20);
    applyStimulus(1, 0, 2'd0, 8'h00, rd, err, cyc, waits);
    checkOutput("w3 b2b rd0", rd, 8'h5A);
    applyStimulus(1, 0, 2'd0, 8'h00, rd, err, cyc, waits);
    checkOutput("w3 b2b rd1", rd, 8'h5B);
    applyStimulus(1, 0, 2'd1, 8'h00, rd, err, cyc, waits);
    checkOutput("w3 b2b status end", rd, 8'h01);

    // Reset in the middle of a waited write must not push anything.
    selDut = 1'b1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
    tick();
    penable = 1'b1;
    tick();
    @(negedge pclk);
    checkOutput("mid pready before reset", pready3, 1'b0);
    preset = 1'b0;
    #1;
    checkOutput("mid reset pready", pready3, 1'b0);
    checkOutput("mid reset prdata", prdata3, 8'h00);
    checkOutput("mid reset pslverr", pslverr3, 1'b0);
    checkOutput("mid reset irq", irq3, 1'b0);
    psel3 = 1'b0; penable = 1'b0;
    tick();
    preset = 1'b1;
    tick();
    modelReset();
    modelXfer(1, 0, 2'd1, 8'h00, "mid after");

    // Pointer wrap on the zero-wait instance.
    doReset();
    for (int i = 0; i < 6; i++) modelXfer(0, 1, 2'd0, 8'(8'h30 + i), "wrap wr");
    for (int i = 0; i < 6; i++) modelXfer(0, 0, 2'd0, 8'h00, "wrap rd");
    for (int i = 0; i < 5; i++) begin
      modelXfer(0, 1, 2'd0, 8'(8'hC0 + i), "wrap iw");
      modelXfer(0, 0, 2'd0, 8'h00, "wrap ir");
    end
    modelXfer(0, 0, 2'd1, 8'h00, "wrap status");

    // Random traffic on each instance against the model.
    for (int d = 0; d < 2; d++) begin
      doReset();
      for (int i = 0; i < (d == 0 ? 250 : 120); i++) begin
        int         pick;
        logic [1:0] a;
        pick = $urandom_range(0, 9);
        a = (pick < 5) ? 2'd0 : (pick < 7) ? 2'd1 : (pick == 7) ? 2'd2 : 2'd3;
        modelXfer(d[0], 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                  $sformatf("rnd d%0d #%0d", d, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
